modn_count_ctrl: RTL

Programmable controller for a mod-N up counter. It accepts a modulus and a run length through a valid/ready configuration handshake, then runs the counter on start/stop/abort commands. It reports terminal-count and completion pulses and holds configuration between runs. It sits between software-visible control registers and the counter datapath it instantiates.

---
 rtl/modn_ctrl_pkg.sv | 33 +++
 rtl/modn_core.sv | 46 ++++
 rtl/modn_count_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/modn_ctrl_pkg.sv
// Shared types for the mod-N counter controller: FSM states, the minimum
// legal modulus and the start/stop/abort priority encoding.
package modn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        PAUSE
    } state_e;

    localparam int MIN_MOD = 2;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_START,
        CMD_STOP,
        CMD_ABORT
    } cmd_e;

    // Several commands in one cycle collapse to one: abort beats stop beats start.
    function automatic cmd_e decode_cmd(input logic start, input logic stop, input logic abort);
        if (abort) begin
            return CMD_ABORT;
        end else if (stop) begin
            return CMD_STOP;
        end else if (start) begin
            return CMD_START;
        end
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/modn_core.sv
// Mod-N counter datapath: count register with enable and synchronous clear,
// plus a registered pulse marking the N-1 -> 0 wrap.
module modn_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] mod_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o,
    output logic             last_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    assign last_o = (count_q == mod_i - WIDTH'(1));

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (en_i) begin
            if (last_o) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;

endmodule

// File: rtl/modn_count_ctrl.sv
// Controller for a programmable mod-N counter: configuration handshake,
// start/stop/abort FSM, wrap counting and completion reporting.
module modn_count_ctrl
    import modn_ctrl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int WRAPS_W = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   cfg_mod,
    input  logic [WRAPS_W-1:0] cfg_wraps,
    input  logic               start,
    input  logic               stop,
    input  logic               abort,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               done,
    output logic               busy,
    output logic               cfg_err
);

    localparam logic [WIDTH-1:0] MinMod = WIDTH'(MIN_MOD);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mod_q, mod_d;
    logic [WRAPS_W-1:0] wraps_q, wraps_d;
    logic [WRAPS_W-1:0] wrapCnt_q, wrapCnt_d;
    logic               done_q, done_d;
    logic               cfgErr_q, cfgErr_d;

    cmd_e               cmd;
    logic               cfgFire;
    logic               coreClr;
    logic               coreEn;
    logic               coreLast;
    logic               coreWrap;
    logic [WIDTH-1:0]   coreCount;

    assign cmd     = decode_cmd(start, stop, abort);
    assign cfgFire = cfg_valid && cfg_ready;

    always_comb begin
        state_d   = state_q;
        mod_d     = mod_q;
        wraps_d   = wraps_q;
        wrapCnt_d = wrapCnt_q;
        done_d    = 1'b0;
        cfgErr_d  = 1'b0;
        coreClr   = 1'b0;
        coreEn    = 1'b0;
        case (state_q)
            IDLE, ARMED: begin
                // A handshake in ARMED takes precedence over a same-cycle start.
                if (cfgFire) begin
                    if (cfg_mod < MinMod) begin
                        cfgErr_d = 1'b1;
                    end else begin
                        mod_d     = cfg_mod;
                        wraps_d   = cfg_wraps;
                        wrapCnt_d = '0;
                        coreClr   = 1'b1;
                        state_d   = ARMED;
                    end
                end else if (state_q == ARMED && cmd == CMD_START) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cmd == CMD_ABORT) begin
                    coreClr   = 1'b1;
                    wrapCnt_d = '0;
                    state_d   = ARMED;
                end else if (cmd == CMD_STOP) begin
                    state_d = PAUSE;
                end else begin
                    coreEn = 1'b1;
                    if (coreLast) begin
                        if (wrapCnt_q != '1) begin
                            wrapCnt_d = wrapCnt_q + WRAPS_W'(1);
                        end
                        if (wraps_q != '0 && (wrapCnt_q + WRAPS_W'(1)) == wraps_q) begin
                            done_d    = 1'b1;
                            wrapCnt_d = '0;
                            state_d   = ARMED;
                        end
                    end
                end
            end
            PAUSE: begin
                if (cmd == CMD_ABORT) begin
                    coreClr   = 1'b1;
                    wrapCnt_d = '0;
                    state_d   = ARMED;
                end else if (cmd == CMD_START) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            mod_q     <= '0;
            wraps_q   <= '0;
            wrapCnt_q <= '0;
            done_q    <= 1'b0;
            cfgErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mod_q     <= mod_d;
            wraps_q   <= wraps_d;
            wrapCnt_q <= wrapCnt_d;
            done_q    <= done_d;
            cfgErr_q  <= cfgErr_d;
        end
    end

    modn_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk    (clk),
        .clr_i  (clr || coreClr),
        .en_i   (coreEn),
        .mod_i  (mod_q),
        .count_o(coreCount),
        .wrap_o (coreWrap),
        .last_o (coreLast)
    );

    assign count     = coreCount;
    assign tc        = coreWrap;
    assign done      = done_q;
    assign cfg_err   = cfgErr_q;
    assign busy      = (state_q == RUN) || (state_q == PAUSE);
    assign cfg_ready = (state_q == IDLE) || (state_q == ARMED);

endmodule
